fpu_writeback_stage: RTL and testbench

- Registered stage directly downstream of the combinational single-precision FPU in the MIPS datapath.
- Accepts each FPU result through a valid/ready handshake.
- Add/sub results go into a small FIFO that drives the FP register-file write port.
- Compare results (c.eq/lt/gt/ge/le.s) update the FP condition flag (FCC) consumed by bc1t/bc1f. Overflow-to-infinity results raise a sticky status flag.

---
 rtl/fpu_writeback_stage.sv | 147 ++++++++++++++
 tb/tb_fpu_writeback_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_writeback_stage
//  Description : FPU result writeback stage. Add/sub results are queued for
//                the FP register file, compares update the FCC flag, and
//                overflow-to-infinity results raise a sticky status flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_writeback_stage #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_result,
    input  logic [3:0]        in_aluop,
    input  logic [ADDR_W-1:0] in_fd,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [31:0]       wb_data,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              fcc,
    output logic              ovf_sticky,
    input  logic              flag_clr
);

    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;
    localparam int C_ENT_W = ADDR_W + 32;

    localparam logic [C_CNT_W-1:0] C_CNT_FULL  = C_CNT_W'(DEPTH);
    localparam logic [C_CNT_W-1:0] C_CNT_EMPTY = '0;
    localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);
    localparam logic [C_PTR_W-1:0] C_PTR_ONE   = C_PTR_W'(1);

    localparam logic [3:0] C_OP_ADD    = 4'd2;
    localparam logic [3:0] C_OP_SUB    = 4'd4;
    localparam logic [3:0] C_OP_C_EQ   = 4'd8;
    localparam logic [3:0] C_OP_C_LT   = 4'd9;
    localparam logic [3:0] C_OP_C_GT   = 4'd10;
    localparam logic [3:0] C_OP_C_GE   = 4'd11;
    localparam logic [3:0] C_OP_C_LE   = 4'd13;

    logic [C_CNT_W-1:0] count_q,  count_d;
    logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic               fcc_q,    fcc_d;
    logic               ovf_q,    ovf_d;

    logic               w_accept;
    logic               w_is_arith;
    logic               w_is_cmp;
    logic               w_push;
    logic               w_pop;
    logic               w_is_inf;
    logic [C_ENT_W-1:0] w_entries [DEPTH];
    logic [C_ENT_W-1:0] w_head;

    // Handshake flags come only from registered occupancy, never from inputs.
    assign in_ready = (count_q != C_CNT_FULL);
    assign wb_valid = (count_q != C_CNT_EMPTY);

    assign w_accept = in_valid & in_ready;
    assign w_push   = w_accept & w_is_arith;
    assign w_pop    = wb_valid & wb_ready;
    assign w_is_inf = (in_result[30:23] == 8'hFF) && (in_result[22:0] == 23'd0);

    always_comb begin
        w_is_arith = 1'b0;
        w_is_cmp   = 1'b0;
        case (in_aluop)
            C_OP_ADD, C_OP_SUB: w_is_arith = 1'b1;
            C_OP_C_EQ, C_OP_C_LT, C_OP_C_GT, C_OP_C_GE, C_OP_C_LE: w_is_cmp = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + C_CNT_ONE;
            2'b01:   count_d = count_q - C_CNT_ONE;
            default: count_d = count_q;
        endcase
        // Power-of-two depth lets the pointers wrap by natural overflow.
        if (w_push) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
        if (w_pop)  rd_ptr_d = rd_ptr_q + C_PTR_ONE;
    end

    always_comb begin
        fcc_d = fcc_q;
        if (w_accept && w_is_cmp) fcc_d = in_result[0];
    end

    // A new overflow takes priority over a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (flag_clr)           ovf_d = 1'b0;
        if (w_push && w_is_inf) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcc_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fcc_q    <= fcc_d;
            ovf_q    <= ovf_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [C_ENT_W-1:0] entry_q;
        logic [C_ENT_W-1:0] entry_d;

        always_comb begin
            entry_d = entry_q;
            if (w_push && (wr_ptr_q == C_PTR_W'(i))) entry_d = {in_fd, in_result};
        end

        // Entries are cleared so the head reads zero straight out of reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) entry_q <= '0;
            else        entry_q <= entry_d;
        end

        assign w_entries[i] = entry_q;
    end

    assign w_head     = w_entries[rd_ptr_q];
    assign wb_addr    = w_head[C_ENT_W-1:32];
    assign wb_data    = w_head[31:0];
    assign fcc        = fcc_q;
    assign ovf_sticky = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_writeback_stage.sv
`default_nettype none
// Self-checking bench for fpu_writeback_stage: directed vector table,
// randomized traffic against a queue-based reference model, and async reset.
module tb_fpu_writeback_stage;

    localparam int DEPTH  = 2;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_result;
    logic [3:0]        in_aluop;
    logic [ADDR_W-1:0] in_fd;
    logic              wb_valid;
    logic              wb_ready;
    logic [31:0]       wb_data;
    logic [ADDR_W-1:0] wb_addr;
    logic              fcc;
    logic              ovf_sticky;
    logic              flag_clr;

    fpu_writeback_stage #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_aluop   (in_aluop),
        .in_fd      (in_fd),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .wb_addr    (wb_addr),
        .fcc        (fcc),
        .ovf_sticky (ovf_sticky),
        .flag_clr   (flag_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } entry_t;

    typedef struct {
        logic              v;
        logic [3:0]        op;
        logic [31:0]       res;
        logic [ADDR_W-1:0] fd;
        logic              wbr;
        logic              clr;
        logic              e_wbv;
        logic [31:0]       e_data;
        logic [ADDR_W-1:0] e_addr;
        logic              e_rdy;
        logic              e_fcc;
        logic              e_ovf;
    } vec_t;

    int     n_checks = 0;
    int     n_fail   = 0;
    entry_t mq[$];
    logic   m_fcc;
    logic   m_ovf;
    vec_t   tbl[16];
    logic [3:0] ops[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model advances on each edge; DUT is checked at the following negedge.
    task automatic step();
        bit     can_take;
        bit     take;
        bit     arith;
        bit     cmp;
        entry_t e;
        can_take = (mq.size() < DEPTH);
        take     = in_valid && can_take;
        arith    = (in_aluop == 4'd2) || (in_aluop == 4'd4);
        cmp      = (in_aluop inside {4'd8, 4'd9, 4'd10, 4'd11, 4'd13});
        @(posedge clk);
        if (mq.size() > 0 && wb_ready) void'(mq.pop_front());
        if (flag_clr) m_ovf = 1'b0;
        if (take && arith) begin
            e.addr = in_fd;
            e.data = in_result;
            mq.push_back(e);
            if (in_result[30:0] == 31'h7F800000) m_ovf = 1'b1;
        end
        if (take && cmp) m_fcc = in_result[0];
        @(negedge clk);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".wb_valid"}, wb_valid, (mq.size() > 0));
        chk({tag, ".in_ready"}, in_ready, (mq.size() < DEPTH));
        chk({tag, ".fcc"}, fcc, m_fcc);
        chk({tag, ".ovf"}, ovf_sticky, m_ovf);
        if (mq.size() > 0) begin
            chk({tag, ".wb_data"}, wb_data, mq[0].data);
            chk({tag, ".wb_addr"}, wb_addr, mq[0].addr);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] res,
                         input logic [ADDR_W-1:0] fd, input logic wbr, input logic clr);
        in_valid  = v;
        in_aluop  = op;
        in_result = res;
        in_fd     = fd;
        wb_ready  = wbr;
        flag_clr  = clr;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          v  op    res           fd   wbr clr  wbv data          addr rdy fcc ovf
        tbl[0]  = '{1, 4'd2, 32'h40400000, 5'd5, 1, 0,   1, 32'h40400000, 5'd5, 1, 0, 0};
        tbl[1]  = '{0, 4'd0, 32'h00000000, 5'd0, 1, 0,   0, 32'h00000000, 5'd0, 1, 0, 0};
        tbl[2]  = '{1, 4'd2, 32'h3F800000, 5'd1, 0, 0,   1, 32'h3F800000, 5'd1, 1, 0, 0};
        tbl[3]  = '{1, 4'd2, 32'h40000000, 5'd2, 0, 0,   1, 32'h3F800000, 5'd1, 0, 0, 0};
        tbl[4]  = '{1, 4'd2, 32'h40400000, 5'd3, 0, 0,   1, 32'h3F800000, 5'd1, 0, 0, 0};
        tbl[5]  = '{1, 4'd9, 32'h00000001, 5'd0, 0, 0,   1, 32'h3F800000, 5'd1, 0, 0, 0};
        tbl[6]  = '{1, 4'd9, 32'h00000001, 5'd0, 1, 0,   1, 32'h40000000, 5'd2, 1, 0, 0};
        tbl[7]  = '{1, 4'd9, 32'h00000001, 5'd0, 0, 0,   1, 32'h40000000, 5'd2, 1, 1, 0};
        tbl[8]  = '{1, 4'd8, 32'h00000000, 5'd0, 0, 0,   1, 32'h40000000, 5'd2, 1, 0, 0};
        tbl[9]  = '{0, 4'd0, 32'h00000000, 5'd0, 1, 0,   0, 32'h00000000, 5'd0, 1, 0, 0};
        tbl[10] = '{1, 4'd2, 32'h7F800000, 5'd7, 1, 0,   1, 32'h7F800000, 5'd7, 1, 0, 1};
        tbl[11] = '{1, 4'd4, 32'hFF800000, 5'd8, 1, 1,   1, 32'hFF800000, 5'd8, 1, 0, 1};
        tbl[12] = '{0, 4'd0, 32'h00000000, 5'd0, 1, 1,   0, 32'h00000000, 5'd0, 1, 0, 0};
        tbl[13] = '{1, 4'd5, 32'h7F800000, 5'd9, 1, 0,   0, 32'h00000000, 5'd0, 1, 0, 0};
        tbl[14] = '{1, 4'd13,32'h00000001, 5'd0, 1, 0,   0, 32'h00000000, 5'd0, 1, 1, 0};
        tbl[15] = '{1, 4'd12,32'h00000000, 5'd0, 1, 0,   0, 32'h00000000, 5'd0, 1, 1, 0};
        ops = '{4'd2, 4'd4, 4'd2, 4'd4, 4'd8, 4'd9, 4'd10, 4'd11, 4'd13, 4'd6};

        // Reset held with a pending add on the input
        rst_n = 1'b0;
        drive(1, 4'd2, 32'h12345678, 5'd3, 1, 0);
        mq.delete();
        m_fcc = 1'b0;
        m_ovf = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.wb_valid", wb_valid, 1'b0);
        chk("rst.wb_data", wb_data, 32'h0);
        chk("rst.wb_addr", wb_addr, 5'd0);
        chk("rst.fcc", fcc, 1'b0);
        chk("rst.ovf", ovf_sticky, 1'b0);
        drive(0, 4'd0, 32'h0, 5'd0, 1, 0);
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready", in_ready, 1'b1);
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].v, tbl[i].op, tbl[i].res, tbl[i].fd, tbl[i].wbr, tbl[i].clr);
            step();
            chk($sformatf("vec%0d.wb_valid", i), wb_valid, tbl[i].e_wbv);
            chk($sformatf("vec%0d.in_ready", i), in_ready, tbl[i].e_rdy);
            chk($sformatf("vec%0d.fcc", i), fcc, tbl[i].e_fcc);
            chk($sformatf("vec%0d.ovf", i), ovf_sticky, tbl[i].e_ovf);
            if (tbl[i].e_wbv) begin
                chk($sformatf("vec%0d.wb_data", i), wb_data, tbl[i].e_data);
                chk($sformatf("vec%0d.wb_addr", i), wb_addr, tbl[i].e_addr);
            end
        end

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r;
            r = $urandom;
            if ($urandom_range(0, 5) == 0) r = {r[31], 8'hFF, 23'd0};
            drive(($urandom_range(0, 3) != 0), ops[$urandom_range(0, 9)], r,
                  ADDR_W'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0));
            step();
            chk_model($sformatf("rnd%0d", n));
        end

        // Asynchronous reset with two entries queued
        for (int k = 0; k < DEPTH + 1; k++) begin
            drive(0, 4'd0, 32'h0, 5'd0, 1, 1);
            step();
        end
        chk_model("pre.drain");
        drive(1, 4'd2, 32'h7F800000, 5'd11, 0, 0);
        step();
        drive(1, 4'd9, 32'h00000001, 5'd0, 0, 0);
        step();
        drive(1, 4'd4, 32'h41200000, 5'd12, 0, 0);
        step();
        chk_model("pre.full");
        drive(0, 4'd0, 32'h0, 5'd0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        m_fcc = 1'b0;
        m_ovf = 1'b0;
        chk("arst.wb_valid", wb_valid, 1'b0);
        chk("arst.in_ready", in_ready, 1'b1);
        chk("arst.wb_data", wb_data, 32'h0);
        chk("arst.fcc", fcc, 1'b0);
        chk("arst.ovf", ovf_sticky, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(0, 4'd0, 32'h0, 5'd0, (k == 2), 0);
            step();
            chk_model($sformatf("post.arst%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
